// File: rtl/hgcal_latent_deserializer.sv
// -----------------------------------------------------------------------------
// hgcal_latent_deserializer
//
// Receive side of the HGCAL autoencoder latent link. Narrow beats of 2-bit
// neuron codes are collected into one full latent frame and presented as a
// parallel word to the decoder LUT layers. Frames with the wrong beat count
// are discarded and flagged. One assembly stage plus one output stage absorb
// downstream backpressure.
//
// Optional feature: define HGCAL_DESER_ERR_CNT_EN to add an 8-bit saturating
// err_count output that counts err_framing pulses.
//
// Ports:
//   clk          in   clock, all logic on rising edge
//   rst          in   synchronous active-high reset
//   s_data       in   W-bit input beat, code i at [i*CODE_BITS +: CODE_BITS]
//   s_valid      in   input beat valid
//   s_last       in   final beat of a frame
//   s_ready      out  beat accepted when s_valid && s_ready
//   m_data       out  assembled frame, NUM_CODES*CODE_BITS bits
//   m_valid      out  frame valid
//   m_ready      in   frame accepted when m_valid && m_ready
//   err_framing  out  one-cycle pulse per discarded frame
//   err_count    out  (HGCAL_DESER_ERR_CNT_EN only) saturating error count
// -----------------------------------------------------------------------------
module hgcal_latent_deserializer #(
    parameter int CODE_BITS  = 2,
    parameter int LANE_CODES = 4,
    parameter int NUM_CODES  = 16,
    localparam int W      = LANE_CODES * CODE_BITS,
    localparam int FW     = NUM_CODES * CODE_BITS,
    localparam int BEATS  = NUM_CODES / LANE_CODES,
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [FW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
`ifdef HGCAL_DESER_ERR_CNT_EN
    output logic [7:0]    err_count,
`endif
    output logic          err_framing
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DROP    = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [FW-1:0]    asm_q;
    logic             asm_full_q;
    logic [FW-1:0]    m_data_q;
    logic             m_valid_q;
    logic             err_q;

    logic [FW-1:0]    asm_merge_d;
    logic             last_beat_s;
    logic             out_free_s;
    logic             accept_s;
    logic             err_set_s;

    // Holding a complete frame in the assembly register is the only reason to stall.
    assign s_ready     = !asm_full_q;
    assign accept_s    = s_valid && !asm_full_q;
    assign last_beat_s = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign out_free_s  = !m_valid_q || m_ready;

    // Short frame (early s_last) or long frame (no s_last on the final slot).
    assign err_set_s = accept_s && (state_q == ST_COLLECT) &&
                       ((!last_beat_s && s_last) || (last_beat_s && !s_last));

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign err_framing = err_q;

    // Assembly word with the incoming beat dropped into its slot; lets a
    // completing frame go straight to the output stage in the same cycle.
    always_comb begin
        asm_merge_d = asm_q;
        asm_merge_d[beat_cnt_q*W +: W] = s_data;
    end

    // Framing FSM, assembly stage and output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            beat_cnt_q <= '0;
            asm_q      <= '0;
            asm_full_q <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_set_s;

            // Drain first; a load below in the same cycle overrides this.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (asm_full_q) begin
                if (out_free_s) begin
                    m_data_q   <= asm_q;
                    m_valid_q  <= 1'b1;
                    asm_full_q <= 1'b0;
                end
            end else if (s_valid) begin
                case (state_q)
                    ST_COLLECT: begin
                        if (!last_beat_s) begin
                            if (s_last) begin
                                beat_cnt_q <= '0;
                            end else begin
                                asm_q      <= asm_merge_d;
                                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            beat_cnt_q <= '0;
                            if (s_last) begin
                                asm_q <= asm_merge_d;
                                if (out_free_s) begin
                                    m_data_q  <= asm_merge_d;
                                    m_valid_q <= 1'b1;
                                end else begin
                                    asm_full_q <= 1'b1;
                                end
                            end else begin
                                state_q <= ST_DROP;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (s_last) begin
                            state_q <= ST_COLLECT;
                        end
                    end
                    default: begin
                        state_q    <= ST_COLLECT;
                        beat_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

`ifdef HGCAL_DESER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    assign err_count = err_cnt_q;

    // Saturating count of framing errors, updated alongside err_framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_set_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hgcal_latent_deserializer.sv
module tb_hgcal_latent_deserializer;

    localparam int W     = 8;
    localparam int FW    = 32;
    localparam int BEATS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          err_framing;
`ifdef HGCAL_DESER_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    hgcal_latent_deserializer dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
`ifdef HGCAL_DESER_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: frames expected at the output, beats of the
    // frame in progress, drop mode, and number of framing errors expected.
    logic [FW-1:0] exp_q[$];
    logic [W-1:0]  cur[$];
    bit            dropping = 1'b0;
    int            exp_err = 0;
    int            err_seen = 0;
    bit            chk_nostall = 1'b0;
    bit            rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model applied to every beat the DUT accepted.
    task automatic model_beat(input logic [W-1:0] d, input logic last);
        logic [FW-1:0] f;
        if (dropping) begin
            if (last) dropping = 1'b0;
            return;
        end
        cur.push_back(d);
        if (cur.size() < BEATS) begin
            if (last) begin
                exp_err++;
                cur.delete();
            end
        end else begin
            if (last) begin
                f = '0;
                for (int k = 0; k < BEATS; k++) f = f | (FW'(cur[k]) << (8 * k));
                exp_q.push_back(f);
            end else begin
                exp_err++;
                dropping = 1'b1;
            end
            cur.delete();
        end
    endtask

    // Present one beat starting at a falling edge; returns at the falling edge
    // after it was accepted.
    task automatic send(input logic [W-1:0] d, input logic last);
        bit acc;
        bit done = 1'b0;
        s_data = d; s_last = last; s_valid = 1'b1;
        for (int w = 0; w < 300; w++) begin
            acc = s_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            model_beat(d, last);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_frame(input logic [FW-1:0] f);
        logic [FW-1:0] t;
        t = f;
        for (int k = 0; k < BEATS; k++) send(t[8*k +: 8], (k == BEATS - 1));
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        idle(3);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_err"}, 64'(err_seen), 64'(exp_err));
    endtask

    // Random backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard: samples just after each falling edge.
    initial begin
        bit            hold_prev = 1'b0;
        logic [FW-1:0] data_prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_data", 64'(m_data), 64'(data_prev));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("frame_data", 64'(m_data), 64'(exp_q.pop_front()));
                    end
                end
                if (err_framing) err_seen++;
                if (chk_nostall) check("no_stall", 64'(s_ready), 64'd1);
                hold_prev = m_valid && !m_ready;
                data_prev = m_data;
            end
        end
    end

    initial begin
        logic [W-1:0] lens[4];
        int len;
        lens[0] = 8'd2; lens[1] = 8'd3; lens[2] = 8'd5; lens[3] = 8'd6;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_err", 64'(err_framing), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd1);

        // Basic frame: m_valid exactly one cycle after the last beat
        send(8'h1B, 1'b0); send(8'hE4, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b1);
        check("basic_valid", 64'(m_valid), 64'd1);
        check("basic_data", 64'(m_data), 64'hFF00E41B);
        @(negedge clk);
        check("basic_pulse", 64'(m_valid), 64'd0);
        drain("basic");

        // Back-to-back frames at full rate
        chk_nostall = 1'b1;
        send_frame(32'hA1B2C3D4);
        send_frame(32'h0F1E2D3C);
        send_frame(32'h55667788);
        chk_nostall = 1'b0;
        drain("b2b");

        // Backpressure
        m_ready = 1'b0;
        send_frame(32'h03020100);
        send_frame(32'h07060504);
        s_data = 8'h99; s_valid = 1'b1; s_last = 1'b0;
        @(negedge clk);
        check("bp_s_ready", 64'(s_ready), 64'd0);
        check("bp_hold_data", 64'(m_data), 64'h03020100);
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", 64'(m_valid), 64'd1);
        check("bp_second_data", 64'(m_data), 64'h07060504);
        check("bp_s_ready_back", 64'(s_ready), 64'd1);
        drain("bp");

        // Short frame then a valid frame
        send(8'h11, 1'b0); send(8'h22, 1'b1);
        send_frame(32'hAA55AA55);
        drain("short");
`ifdef HGCAL_DESER_ERR_CNT_EN
        check("short_err_count", 64'(err_count), 64'd1);
`endif

        // Long frame: 6 beats, then a valid frame
        for (int k = 0; k < 6; k++) send(8'(8'h30 + k), (k == 5));
        send_frame(32'hC0FFEE01);
        drain("long");

        // Reset mid-frame
        send(8'hDE, 1'b0); send(8'hAD, 1'b0);
        rst = 1'b1;
        cur.delete(); dropping = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(m_valid), 64'd0);
        check("midrst_data", 64'(m_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(32'h12345678);
        drain("midrst");
        exp_err = 0; err_seen = 0;
`ifdef HGCAL_DESER_ERR_CNT_EN
        check("midrst_err_count", 64'(err_count), 64'd0);
`endif

        // Randomized frames, lengths and backpressure
        rand_rdy = 1'b1;
        for (int fr = 0; fr < 40; fr++) begin
            len = ($urandom_range(0, 9) < 7) ? BEATS : int'(lens[$urandom_range(0, 3)]);
            for (int k = 0; k < len; k++) begin
                send(8'($urandom), (k == len - 1));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        drain("random");
`ifdef HGCAL_DESER_ERR_CNT_EN
        check("random_err_count", 64'(err_count), 64'(exp_err > 255 ? 255 : exp_err));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
